// File: rtl/sm4_pkg.sv
// Shared definitions for the SM4 control blocks.
//   SM4_BLK_W    : data block width
//   SM4_KEY_W    : master key width
//   ctrl_state_e : sequencer state encoding used by sm4_keyexp_ctrl
package sm4_pkg;

  localparam int SM4_BLK_W = 128;
  localparam int SM4_KEY_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_KSTART  = 3'd1,
    ST_KWAIT   = 3'd2,
    ST_KSETTLE = 3'd3,
    ST_CSTART  = 3'd4,
    ST_CWAIT   = 3'd5,
    ST_RESP    = 3'd6
  } ctrl_state_e;

endpackage

// File: rtl/sm4_ctrl_timer.sv
// Loadable saturating cycle counter used for the key-expansion / crypt
// timeouts and for the post-expansion settle delay.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear (count restarts at 0 next cycle)
//   count_o    : current count, saturates at all-ones
//   expire_o   : count_o == TIMEOUT-1
module sm4_ctrl_timer
  import sm4_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             expire_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] EXP_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o  = cnt_q;
  assign expire_o = (cnt_q == EXP_VAL);

endmodule

// File: rtl/sm4_keyexp_ctrl.sv
// Sequencer in front of the SM4 key-expansion unit and round datapath.
// Caches the last successfully expanded key+mode; key expansion is only
// re-run on a cache miss. Results are returned over a valid/ready channel.
//   req_*   : request channel (key, enc/dec, data block)
//   flush   : invalidate the key cache
//   rsp_*   : response channel (data, timeout error flag)
//   kexp_*  : key-expansion unit control (start pulse, key, mode, done)
//   crypt_* : round datapath control (start pulse, block in/out, done)
//   busy    : sequencer not idle
//   key_hit : one-cycle pulse after an accept that hit the key cache
module sm4_keyexp_ctrl
  import sm4_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int SETTLE  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SM4_KEY_W-1:0] req_key,
  input  logic                 req_dec,
  input  logic [SM4_BLK_W-1:0] req_data,
  input  logic                 flush,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [SM4_BLK_W-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 kexp_start,
  output logic [SM4_KEY_W-1:0] kexp_mkey,
  output logic                 kexp_dec,
  input  logic                 kexp_done,
  output logic                 crypt_start,
  output logic [SM4_BLK_W-1:0] crypt_din,
  input  logic                 crypt_done,
  input  logic [SM4_BLK_W-1:0] crypt_dout,
  output logic                 busy,
  output logic                 key_hit
);

  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);

  ctrl_state_e          state_q, state_d;
  logic [SM4_KEY_W-1:0] mkey_q, mkey_d;
  logic                 kdec_q, kdec_d;
  logic [SM4_BLK_W-1:0] din_q, din_d;
  logic                 cache_vld_q, cache_vld_d;
  logic [SM4_KEY_W-1:0] cache_key_q, cache_key_d;
  logic                 cache_dec_q, cache_dec_d;
  logic [SM4_BLK_W-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 req_ready_q, req_ready_d;
  logic                 key_hit_q, key_hit_d;

  logic             accept;
  logic             hit;
  logic             tmr_clr;
  logic             tmr_expire;
  logic [TMR_W-1:0] tmr_count;

  assign accept = req_valid && req_ready_q;
  assign hit    = cache_vld_q && (req_key == cache_key_q) && (req_dec == cache_dec_q);

  // The timer restarts on every state change, so it reads 0 in the first
  // cycle of KWAIT, KSETTLE and CWAIT.
  assign tmr_clr = (state_d != state_q);

  sm4_ctrl_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tmr_clr),
    .count_o  (tmr_count),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    mkey_d      = mkey_q;
    kdec_d      = kdec_q;
    din_d       = din_q;
    cache_vld_d = cache_vld_q;
    cache_key_d = cache_key_q;
    cache_dec_d = cache_dec_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    key_hit_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mkey_d    = req_key;
          kdec_d    = req_dec;
          din_d     = req_data;
          key_hit_d = hit;
          if (hit) begin
            state_d = ST_CSTART;
          end else begin
            // Round keys are about to be overwritten, so the cache is stale
            // until this expansion settles.
            cache_vld_d = 1'b0;
            state_d     = ST_KSTART;
          end
        end
      end
      ST_KSTART: state_d = ST_KWAIT;
      ST_KWAIT: begin
        if (kexp_done) begin
          state_d = ST_KSETTLE;
        end else if (tmr_expire) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = ST_RESP;
        end
      end
      ST_KSETTLE: begin
        if (tmr_count == SETTLE_LAST) begin
          cache_vld_d = 1'b1;
          cache_key_d = mkey_q;
          cache_dec_d = kdec_q;
          state_d     = ST_CSTART;
        end
      end
      ST_CSTART: state_d = ST_CWAIT;
      ST_CWAIT: begin
        if (crypt_done) begin
          rsp_err_d  = 1'b0;
          rsp_data_d = crypt_dout;
          state_d    = ST_RESP;
        end else if (tmr_expire) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush has the last word, including over a settle completion.
    if (flush) begin
      cache_vld_d = 1'b0;
    end

    // Registered so that req_ready reads 0 while reset is held.
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mkey_q      <= '0;
      kdec_q      <= 1'b0;
      din_q       <= '0;
      cache_vld_q <= 1'b0;
      cache_key_q <= '0;
      cache_dec_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      req_ready_q <= 1'b0;
      key_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mkey_q      <= mkey_d;
      kdec_q      <= kdec_d;
      din_q       <= din_d;
      cache_vld_q <= cache_vld_d;
      cache_key_q <= cache_key_d;
      cache_dec_q <= cache_dec_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= req_ready_d;
      key_hit_q   <= key_hit_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign kexp_start  = (state_q == ST_KSTART);
  assign kexp_mkey   = mkey_q;
  assign kexp_dec    = kdec_q;
  assign crypt_start = (state_q == ST_CSTART);
  assign crypt_din   = din_q;
  assign busy        = (state_q != ST_IDLE);
  assign key_hit     = key_hit_q;

endmodule

// File: tb/tb_sm4_keyexp_ctrl.sv
module tb_sm4_keyexp_ctrl;

  localparam int TIMEOUT = 64;
  localparam int SETTLE  = 1;
  localparam logic [127:0] SM4_K = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] SM4_P = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] SM4_C = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] K2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K3 = 128'hdeadbeef0badf00dcafebabe12345678;
  localparam logic [127:0] D1 = 128'h11111111222222223333333344444444;
  localparam logic [127:0] D2 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] D3 = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] D4 = 128'h5555aaaa5555aaaa5555aaaa5555aaaa;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [127:0] req_key = '0;
  logic         req_dec = 1'b0;
  logic [127:0] req_data = '0;
  logic         flush = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_data;
  logic         rsp_err;
  logic         kexp_start;
  logic [127:0] kexp_mkey;
  logic         kexp_dec;
  logic         kexp_done = 1'b0;
  logic         crypt_start;
  logic [127:0] crypt_din;
  logic         crypt_done = 1'b0;
  logic [127:0] crypt_dout = '0;
  logic         busy;
  logic         key_hit;

  sm4_keyexp_ctrl #(.TIMEOUT(TIMEOUT), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .req_dec(req_dec), .req_data(req_data), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .kexp_start(kexp_start), .kexp_mkey(kexp_mkey), .kexp_dec(kexp_dec), .kexp_done(kexp_done),
    .crypt_start(crypt_start), .crypt_din(crypt_din), .crypt_done(crypt_done),
    .crypt_dout(crypt_dout), .busy(busy), .key_hit(key_hit)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference cipher: the two published SM4 vectors, otherwise a toy
  // keyed add/subtract so that encrypt and decrypt differ.
  function automatic logic [127:0] ref_cipher(input logic [127:0] k, input logic d,
                                              input logic [127:0] x);
    if (k == SM4_K && !d && x == SM4_P) return SM4_C;
    if (k == SM4_K && d && x == SM4_C) return SM4_P;
    return d ? (x - k) : (x + k);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- behavioural core models ----------------
  int kcnt = 0, ccnt = 0, kd_cnt = 0, kd_cyc = 0, cd_cnt = 0, cd_cyc = 0;
  int spur_req = 0, spur_ack = 0;
  bit kexp_hang = 0, crypt_hang = 0, rk_vld = 0;
  logic [127:0] rk_key = '0, cin = '0;
  logic rk_dec = 1'b0;

  always @(negedge clk) begin
    kexp_done  = 1'b0;
    crypt_done = 1'b0;
    crypt_dout = rand128();
    if (!rst_n) begin
      kcnt = 0;
      ccnt = 0;
    end else begin
      if (kcnt > 0) begin
        kcnt--;
        if (kcnt == 0 && !kexp_hang) begin
          kexp_done = 1'b1;
          rk_key = kexp_mkey;
          rk_dec = kexp_dec;
          rk_vld = 1;
          kd_cnt++;
          kd_cyc = cyc;
        end
      end
      if (kexp_start) kcnt = 32;
      if (ccnt > 0) begin
        ccnt--;
        if (ccnt == 0 && !crypt_hang) begin
          crypt_done = 1'b1;
          crypt_dout = rk_vld ? ref_cipher(rk_key, rk_dec, cin) : '0;
          cd_cnt++;
          cd_cyc = cyc;
        end
      end
      if (crypt_start) begin
        ccnt = 32;
        cin = crypt_din;
      end
      if (spur_req != spur_ack) begin
        kexp_done  = 1'b1;
        crypt_done = 1'b1;
        spur_ack   = spur_req;
      end
    end
  end

  // ---------------- output monitor ----------------
  int kst_cnt = 0, kst_cyc = 0, cst_cnt = 0, cst_cyc = 0, kh_cnt = 0, kh_cyc = 0, kdec_bad = 0;
  logic kdec_at_start = 1'b0;
  logic [127:0] kmkey_at_start = '0;
  bit kwin = 0;

  always @(negedge clk) begin
    if (kexp_start) begin
      kst_cnt++;
      kst_cyc = cyc;
      kdec_at_start = kexp_dec;
      kmkey_at_start = kexp_mkey;
      kwin = 1;
    end else if (kwin && kexp_dec !== kdec_at_start) begin
      kdec_bad++;
    end
    if (crypt_start || !busy) kwin = 0;
    if (crypt_start) begin
      cst_cnt++;
      cst_cyc = cyc;
    end
    if (key_hit) begin
      kh_cnt++;
      kh_cyc = cyc;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  // Reference key cache
  bit m_vld = 0;
  logic [127:0] m_key = '0;
  logic m_dec = 1'b0;
  int txn = 0;

  task automatic do_req(input logic [127:0] k, input logic d, input logic [127:0] din,
                        input bit exp_hit, input bit exp_err, input logic [127:0] exp_data,
                        input int hold, input bit fl, input bit khang, input bit chang,
                        input string nm);
    int kst0, cst0, kh0, kd0, kbad0, acc, rv, n, fl_state;
    kexp_hang = khang;
    crypt_hang = chang;
    kst0 = kst_cnt; cst0 = cst_cnt; kh0 = kh_cnt; kd0 = kd_cnt; kbad0 = kdec_bad;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin nstep(); n++; end
    chki({nm, "_req_ready"}, int'(req_ready), 1);
    req_valid = 1'b1; req_key = k; req_dec = d; req_data = din;
    acc = cyc;
    nstep();
    req_valid = 1'b0; req_key = rand128(); req_data = rand128(); req_dec = ~d;
    n = 0; fl_state = 0;
    while (rsp_valid !== 1'b1 && n < 300) begin
      if (fl_state == 1) begin flush = 1'b1; fl_state = 2; end
      else if (fl_state == 2) begin flush = 1'b0; fl_state = 3; end
      if (fl && fl_state == 0 && kd_cnt != kd0) fl_state = 1;
      nstep();
      n++;
    end
    flush = 1'b0;
    rv = cyc;
    chki({nm, "_rsp_valid"}, int'(rsp_valid), 1);
    chki({nm, "_key_hit"}, kh_cnt - kh0, exp_hit ? 1 : 0);
    if (exp_hit) begin
      chki({nm, "_hit_no_kstart"}, kst_cnt - kst0, 0);
      chki({nm, "_hit_key_hit_lat"}, kh_cyc, acc + 1);
      chki({nm, "_hit_cstart_lat"}, cst_cyc, acc + 1);
    end else begin
      chki({nm, "_kstart_cnt"}, kst_cnt - kst0, 1);
      chki({nm, "_kstart_lat"}, kst_cyc, acc + 1);
      chk({nm, "_kexp_mkey"}, kmkey_at_start, k);
      chki({nm, "_kexp_dec"}, int'(kdec_at_start), int'(d));
      chki({nm, "_kexp_dec_held"}, kdec_bad - kbad0, 0);
      if (khang) begin
        chki({nm, "_ktimeout_lat"}, rv, kst_cyc + TIMEOUT + 1);
        chki({nm, "_no_cstart"}, cst_cnt - cst0, 0);
      end else begin
        chki({nm, "_cstart_after_kdone"}, cst_cyc, kd_cyc + SETTLE + 1);
      end
    end
    if (!khang) begin
      if (chang) chki({nm, "_ctimeout_lat"}, rv, cst_cyc + TIMEOUT + 1);
      else chki({nm, "_rsp_lat"}, rv, cd_cyc + 1);
    end
    chk({nm, "_rsp_data"}, rsp_data, exp_data);
    chki({nm, "_rsp_err"}, int'(rsp_err), int'(exp_err));
    for (int i = 0; i < hold; i++) begin
      nstep();
      chki({nm, "_hold_valid_ready"}, int'({rsp_valid, req_ready}), 2);
      chk({nm, "_hold_data"}, rsp_data, exp_data);
    end
    rsp_ready = 1'b1;
    nstep();
    rsp_ready = 1'b0;
    chki({nm, "_back_idle"}, int'({rsp_valid, busy, req_ready}), 1);
    if (!exp_hit) begin
      m_vld = !khang && !fl;
      m_key = k;
      m_dec = d;
    end
    $display("txn %0d %s key=%h dec=%0d hit=%0d err=%0d data=%h", txn, nm, k, d,
             kh_cnt - kh0, rsp_err, rsp_data);
    txn++;
  endtask

  task automatic chk_all_zero(input string nm);
    chki({nm, "_ctl"}, int'({req_ready, rsp_valid, rsp_err, kexp_start, kexp_dec,
                             crypt_start, busy, key_hit}), 0);
    chk({nm, "_rsp_data"}, rsp_data, '0);
    chk({nm, "_kexp_mkey"}, kexp_mkey, '0);
    chk({nm, "_crypt_din"}, crypt_din, '0);
  endtask

  typedef struct {
    logic [127:0] key;
    logic         dec;
    logic [127:0] data;
    bit           khang;
    bit           chang;
    bit           fl;
    int           hold;
    bit           exp_hit;
    bit           exp_err;
    logic [127:0] exp_data;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #1000000;
    $display("FAIL watchdog: got still running required finished");
    $fatal(1);
  end

  initial begin
    int n;
    int cst0;
    // key, dec, data, khang, chang, flush-in-settle, hold, exp_hit, exp_err, exp_data
    tbl[0]  = '{SM4_K, 1'b0, SM4_P, 0, 0, 0, 0, 0, 0, SM4_C};
    tbl[1]  = '{SM4_K, 1'b0, SM4_C, 0, 0, 0, 0, 1, 0, ref_cipher(SM4_K, 1'b0, SM4_C)};
    tbl[2]  = '{SM4_K, 1'b1, SM4_C, 0, 0, 0, 0, 0, 0, SM4_P};
    tbl[3]  = '{SM4_K, 1'b1, SM4_C, 0, 0, 0, 1, 1, 0, SM4_P};
    tbl[4]  = '{K2,    1'b0, D1,    1, 0, 0, 0, 0, 1, '0};
    tbl[5]  = '{K2,    1'b0, D1,    0, 0, 0, 0, 0, 0, ref_cipher(K2, 1'b0, D1)};
    tbl[6]  = '{K2,    1'b0, D2,    0, 0, 0, 10, 1, 0, ref_cipher(K2, 1'b0, D2)};
    tbl[7]  = '{K3,    1'b0, D3,    0, 0, 1, 0, 0, 0, ref_cipher(K3, 1'b0, D3)};
    tbl[8]  = '{K3,    1'b0, D3,    0, 0, 0, 0, 0, 0, ref_cipher(K3, 1'b0, D3)};
    tbl[9]  = '{K3,    1'b0, D4,    0, 1, 0, 2, 1, 1, '0};
    tbl[10] = '{K3,    1'b0, D4,    0, 0, 0, 0, 1, 0, ref_cipher(K3, 1'b0, D4)};

    // Reset
    rst_n = 1'b0;
    repeat (3) nstep();
    chk_all_zero("reset");
    rst_n = 1'b1;
    nstep();
    chki("reset_release_ready_busy", int'({req_ready, busy}), 2);

    // Directed table
    for (int i = 0; i < 11; i++) begin
      do_req(tbl[i].key, tbl[i].dec, tbl[i].data, tbl[i].exp_hit, tbl[i].exp_err,
             tbl[i].exp_data, tbl[i].hold, tbl[i].fl, tbl[i].khang, tbl[i].chang, "tbl");
    end
    kexp_hang = 0;
    crypt_hang = 0;

    // Reset while the crypt core is running: no response, cache invalidated
    cst0 = cst_cnt;
    req_valid = 1'b1; req_key = K3; req_dec = 1'b1; req_data = D4;
    nstep();
    req_valid = 1'b0;
    n = 0;
    while (cst_cnt == cst0 && n < 100) begin nstep(); n++; end
    chki("rstmid_cstart_seen", cst_cnt - cst0, 1);
    repeat (5) nstep();
    rst_n = 1'b0;
    nstep();
    chk_all_zero("rstmid");
    rst_n = 1'b1;
    m_vld = 0;
    n = 0;
    repeat (50) begin
      nstep();
      if (rsp_valid === 1'b1) n++;
    end
    chki("rstmid_no_response", n, 0);
    chki("rstmid_idle", int'({req_ready, busy}), 2);
    do_req(K3, 1'b1, D4, 0, 0, ref_cipher(K3, 1'b1, D4), 0, 0, 0, 0, "post_rst");

    // Randomized traffic against the reference cache and cipher
    for (int i = 0; i < 30; i++) begin
      logic [127:0] k;
      logic [127:0] x;
      logic d;
      bit eh;
      int sel;
      sel = $urandom_range(0, 2);
      k = (sel == 0) ? SM4_K : (sel == 1) ? K2 : K3;
      d = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        k = m_key;
        d = m_dec;
      end
      x = rand128();
      if ($urandom_range(0, 4) == 0) begin
        flush = 1'b1;
        nstep();
        flush = 1'b0;
        m_vld = 0;
      end
      if ($urandom_range(0, 4) == 0) begin
        spur_req++;
        nstep();
        nstep();
        chki("spurious_done_idle", int'({busy, rsp_valid, req_ready}), 1);
      end
      eh = m_vld && (k == m_key) && (d == m_dec);
      do_req(k, d, x, eh, 0, ref_cipher(k, d, x), $urandom_range(0, 2), 0, 0, 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
